// File: rtl/ring_scan_pkg.sv
// Shared types and constants for the ring-counter digit scanner.
// Segment table is ordered {g,f,e,d,c,b,a}, active-high.
package ring_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } scan_state_t;

   localparam logic [3:0] PHASE_START = 4'b0001;
   localparam logic [3:0] PHASE_LAST  = 4'b1000;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
      7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
   };

   function automatic logic [3:0] rotl(input logic [3:0] v);
      return {v[2:0], v[3]};
   endfunction

endpackage

// File: rtl/ring_digit_scanner_hex7seg.sv
// Combinational hex-to-seven-segment decoder.
module hex7seg
   import ring_scan_pkg::*;
(
   input  logic [3:0] val,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[val];

endmodule

// File: rtl/ring_digit_scanner.sv
// Drives a 4-digit multiplexed display from a one-hot ring phase and
// supervises the ring sequence (faults, stalls, completed rotations).
module ring_digit_scanner
   import ring_scan_pkg::*;
#(
   parameter int STALL_CYCLES = 8,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       phase,
   input  logic [15:0]      digits,
   output logic [3:0]       an,
   output logic [6:0]       seg,
   output logic             err,
   output logic             stall,
   output logic [CNT_W-1:0] rotations
);

   localparam logic [7:0] STALL_MAX = 8'(STALL_CYCLES);

   scan_state_t state;
   logic [3:0]  prev;
   logic [7:0]  stall_cnt;
   logic [3:0]  sel_digit;
   logic [6:0]  seg_dec;

   // Non-one-hot phases never reach the display, so their mux value is moot.
   always_comb begin
      sel_digit = digits[3:0];
      case (phase)
         4'b0010: sel_digit = digits[7:4];
         4'b0100: sel_digit = digits[11:8];
         4'b1000: sel_digit = digits[15:12];
         default: sel_digit = digits[3:0];
      endcase
   end

   hex7seg u_dec (
      .val(sel_digit),
      .seg(seg_dec)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         prev      <= 4'b0000;
         stall_cnt <= 8'd0;
         an        <= 4'b0000;
         seg       <= 7'b0000000;
         err       <= 1'b0;
         stall     <= 1'b0;
         rotations <= '0;
      end else begin
         an  <= 4'b0000;
         seg <= 7'b0000000;
         case (state)
            IDLE: begin
               if (phase == PHASE_START) begin
                  state     <= TRACK;
                  prev      <= phase;
                  stall_cnt <= 8'd0;
                  an        <= phase;
                  seg       <= seg_dec;
               end
            end
            TRACK: begin
               if (phase == prev) begin
                  if (stall_cnt != STALL_MAX)
                     stall_cnt <= stall_cnt + 8'd1;
                  stall <= (stall_cnt >= STALL_MAX - 8'd1);
                  an    <= phase;
                  seg   <= seg_dec;
               end else if (phase == rotl(prev)) begin
                  stall_cnt <= 8'd0;
                  stall     <= 1'b0;
                  prev      <= phase;
                  an        <= phase;
                  seg       <= seg_dec;
                  if (prev == PHASE_LAST)
                     rotations <= rotations + CNT_W'(1);
               end else begin
                  state     <= FAULT;
                  err       <= 1'b1;
                  stall     <= 1'b0;
                  stall_cnt <= 8'd0;
               end
            end
            FAULT: begin
               stall_cnt <= 8'd0;
               stall     <= 1'b0;
               if (phase == PHASE_START) begin
                  state <= TRACK;
                  prev  <= phase;
                  an    <= phase;
                  seg   <= seg_dec;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ring_digit_scanner.sv
// Directed bench for ring_digit_scanner with hand-computed expectations.
module tb_ring_digit_scanner;

   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic [3:0]       phase;
   logic [15:0]      digits;
   logic [3:0]       an;
   logic [6:0]       seg;
   logic             err;
   logic             stall;
   logic [CNT_W-1:0] rotations;

   int n_tests = 0;
   int n_fail  = 0;

   ring_digit_scanner #(.STALL_CYCLES(8), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .phase(phase), .digits(digits),
      .an(an), .seg(seg), .err(err), .stall(stall), .rotations(rotations)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic [3:0] p);
      phase = p;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset  = 1'b1;
      phase  = 4'b0000;
      digits = 16'h4321;
      @(posedge clk); #1;
      chk("rst_an", 32'(an), 32'h0);
      chk("rst_seg", 32'(seg), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_rot", 32'(rotations), 32'h0);
      reset = 1'b0;

      // idle ignores non-start codes
      cyc(4'b0000);
      chk("idle0_an", 32'(an), 32'h0);
      chk("idle0_err", 32'(err), 32'h0);
      cyc(4'b1000);
      chk("idle8_an", 32'(an), 32'h0);
      chk("idle8_seg", 32'(seg), 32'h0);
      chk("idle8_err", 32'(err), 32'h0);

      // one full rotation, digits 4321
      cyc(4'b0001);
      chk("r_an1", 32'(an), 32'h1);  chk("r_seg1", 32'(seg), 32'h06);
      cyc(4'b0010);
      chk("r_an2", 32'(an), 32'h2);  chk("r_seg2", 32'(seg), 32'h5b);
      cyc(4'b0100);
      chk("r_an4", 32'(an), 32'h4);  chk("r_seg4", 32'(seg), 32'h4f);
      chk("r_rot_mid", 32'(rotations), 32'h0);
      cyc(4'b1000);
      chk("r_an8", 32'(an), 32'h8);  chk("r_seg8", 32'(seg), 32'h66);
      cyc(4'b0001);
      chk("r_an1b", 32'(an), 32'h1); chk("r_seg1b", 32'(seg), 32'h06);
      chk("r_rot", 32'(rotations), 32'h1);
      chk("r_err", 32'(err), 32'h0);

      // ten rotations from fresh reset wrap the 3-bit counter
      reset = 1'b1; #2; reset = 1'b0;
      cyc(4'b0001);
      for (int i = 1; i <= 10; i++) begin
         cyc(4'b0010); cyc(4'b0100); cyc(4'b1000); cyc(4'b0001);
         if (i == 7) chk("wrap_7", 32'(rotations), 32'h7);
         if (i == 8) chk("wrap_0", 32'(rotations), 32'h0);
      end
      chk("wrap_end", 32'(rotations), 32'h2);
      chk("wrap_err", 32'(err), 32'h0);

      // stall: 0100 sampled 9 times (1 advance + 8 repeats)
      cyc(4'b0010);
      for (int i = 1; i <= 8; i++) cyc(4'b0100);
      chk("stall_pre", 32'(stall), 32'h0);
      cyc(4'b0100);
      chk("stall_on", 32'(stall), 32'h1);
      chk("stall_an", 32'(an), 32'h4);
      cyc(4'b0100);
      chk("stall_sat", 32'(stall), 32'h1);
      cyc(4'b1000);
      chk("stall_off", 32'(stall), 32'h0);
      chk("stall_an8", 32'(an), 32'h8);

      // fault then resync
      cyc(4'b0001);
      cyc(4'b0010);
      cyc(4'b0110);
      chk("flt_err", 32'(err), 32'h1);
      chk("flt_an", 32'(an), 32'h0);
      chk("flt_seg", 32'(seg), 32'h0);
      cyc(4'b0100);
      chk("flt_hold_an", 32'(an), 32'h0);
      cyc(4'b0001);
      chk("resync_an", 32'(an), 32'h1);
      chk("resync_seg", 32'(seg), 32'h06);
      chk("resync_err", 32'(err), 32'h1);
      cyc(4'b0010);
      chk("resync_an2", 32'(an), 32'h2);
      digits = 16'h4381;
      cyc(4'b0010);
      chk("dig_upd", 32'(seg), 32'h7f);
      chk("dig_err", 32'(err), 32'h1);

      // async reset mid-cycle
      cyc(4'b0100);
      #3 reset = 1'b1;
      #1;
      chk("ar_an", 32'(an), 32'h0);
      chk("ar_seg", 32'(seg), 32'h0);
      chk("ar_err", 32'(err), 32'h0);
      chk("ar_stall", 32'(stall), 32'h0);
      chk("ar_rot", 32'(rotations), 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      cyc(4'b0010);
      chk("ar_ign_an", 32'(an), 32'h0);
      cyc(4'b0001);
      chk("ar_start_an", 32'(an), 32'h1);
      chk("ar_start_seg", 32'(seg), 32'h06);

      // decode boundaries 0, 8, F
      digits = 16'hF800;
      cyc(4'b0010);
      chk("hex_0", 32'(seg), 32'h3f);
      cyc(4'b0100);
      chk("hex_8", 32'(seg), 32'h7f);
      cyc(4'b1000);
      chk("hex_f", 32'(seg), 32'h71);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
